// File: rtl/lwc_do_receiver_if.sv
// LWC DO-side stream plus payload sink bundle.
// master drives the DO words and sink ready; slave is the receiver.
interface lwc_do_receiver_if #(
  parameter int BUSW = 32
);
  logic [BUSW-1:0]   do_data;
  logic              do_valid;
  logic              do_last;
  logic              do_ready;
  logic [BUSW-1:0]   out_data;
  logic [BUSW/8-1:0] out_keep;
  logic [3:0]        out_type;
  logic              out_eot;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output do_data, do_valid, do_last, out_ready,
    input  do_ready, out_data, out_keep, out_type,
    input  out_eot, out_valid
  );

  modport slave (
    input  do_data, do_valid, do_last, out_ready,
    output do_ready, out_data, out_keep, out_type,
    output out_eot, out_valid
  );
endinterface

// File: rtl/lwc_do_receiver.sv
// LWC DO receiver: parses headers/status, forwards payload with keep.
// Define LWC_DO_BYTECNT_EN to build the pld_bytes payload counter.
module lwc_do_receiver #(
  parameter int       BUSW         = 32,
  parameter bit [3:0] STAT_SUCCESS = 4'hE,
  parameter bit [3:0] STAT_FAILURE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  lwc_do_receiver_if.slave  bus,
  output logic              msg_done,
  output logic              msg_success,
  output logic              proto_err,
  output logic [15:0]       pld_bytes
);
  localparam int W = BUSW / 8;

  localparam logic [1:0] HDR  = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]   state;
  logic [15:0]  rem_len;
  logic [3:0]   seg_type;
  logic         seg_last;
  logic [3:0]   w_type;
  logic         is_stat;
  logic         final_w;
  logic [15:0]  step;
  logic [W-1:0] keep_nx;
  logic         xfer_in;
  logic         xfer_out;

  assign w_type   = bus.do_data[BUSW-1 -: 4];
  assign is_stat  = (w_type == STAT_SUCCESS) ||
                    (w_type == STAT_FAILURE);
  assign final_w  = rem_len <= 16'(W);
  assign step     = final_w ? rem_len : 16'(W);
  assign xfer_in  = bus.do_valid && bus.do_ready;
  assign xfer_out = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.do_ready = 1'b0;
    unique case (state)
      HDR:     bus.do_ready = !rst;
      DATA:    bus.do_ready = !rst &&
                 (!bus.out_valid || bus.out_ready);
      ERR:     bus.do_ready = !rst;
      default: bus.do_ready = 1'b0;
    endcase
  end

  // Byte i (counted from the MSB lane) is valid while i < rem_len.
  always_comb begin
    keep_nx = '0;
    for (int i = 0; i < W; i++)
      keep_nx[W-1-i] = 16'(i) < rem_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      rem_len       <= '0;
      seg_type      <= '0;
      seg_last      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
      bus.out_type  <= '0;
      bus.out_eot   <= 1'b0;
      msg_done      <= 1'b0;
      msg_success   <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      if (xfer_out)
        bus.out_valid <= 1'b0;
      if (xfer_in) begin
        unique case (state)
          HDR: begin
            if (is_stat) begin
              if (bus.do_last) begin
                msg_done    <= 1'b1;
                msg_success <= w_type == STAT_SUCCESS;
              end else begin
                state     <= ERR;
                proto_err <= 1'b1;
              end
            end else if (bus.do_last) begin
              state     <= ERR;
              proto_err <= 1'b1;
            end else begin
              seg_type <= w_type;
              seg_last <= bus.do_data[BUSW-7];
              rem_len  <= bus.do_data[15:0];
              if (bus.do_data[15:0] != 16'd0)
                state <= DATA;
            end
          end
          DATA: begin
            if (bus.do_last) begin
              state     <= ERR;
              proto_err <= 1'b1;
            end else begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.do_data;
              bus.out_keep  <= keep_nx;
              bus.out_type  <= seg_type;
              bus.out_eot   <= final_w && seg_last;
              rem_len       <= rem_len - step;
              if (final_w)
                state <= HDR;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LWC_DO_BYTECNT_EN
  logic [15:0] kcnt;
  logic [16:0] psum;

  always_comb begin
    kcnt = '0;
    for (int i = 0; i < W; i++)
      kcnt = kcnt + 16'(bus.out_keep[i]);
    psum = {1'b0, pld_bytes} + {1'b0, kcnt};
  end

  // Clear wins over a same-cycle transfer: the message is closed.
  always_ff @(posedge clk) begin
    if (rst || msg_done)
      pld_bytes <= '0;
    else if (xfer_out)
      pld_bytes <= psum[16] ? 16'hFFFF : psum[15:0];
  end
`else
  assign pld_bytes = '0;
`endif
endmodule

// File: tb/tb_lwc_do_receiver.sv
// Randomized scoreboard bench for lwc_do_receiver (BUSW=32).
module tb_lwc_do_receiver;
  logic        clk = 1'b0;
  logic        rst;
  logic        msg_done;
  logic        msg_success;
  logic        proto_err;
  logic [15:0] pld_bytes;

  lwc_do_receiver_if #(.BUSW(32)) bus ();

  lwc_do_receiver #(.BUSW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .msg_done    (msg_done),
    .msg_success (msg_success),
    .proto_err   (proto_err),
    .pld_bytes   (pld_bytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  t;
    logic        e;
  } ow_t;

  logic [31:0] wq[$];
  bit          lq[$];
  bit          dq[$];
  logic [31:0] pay_q[$];
  ow_t         exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  bit succ_model = 0;
  int pld_model = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push_w(input logic [31:0] w,
                                 input bit l, input bit d);
    wq.push_back(w);
    lq.push_back(l);
    dq.push_back(d);
  endfunction

  // Expected payload is derived only from the header fields.
  function automatic void add_seg(input logic [31:0] h);
    int  len;
    int  rem;
    ow_t o;
    logic [7:0] msk;
    len = int'(h[15:0]);
    push_w(h, 1'b0, 1'b0);
    for (int i = 0; i < (len + 3) / 4; i++) begin
      o.d = (pay_q.size() != 0) ? pay_q.pop_front() : $urandom;
      rem = len - 4 * i;
      msk = 8'hF0 >> rem;
      o.k = (rem >= 4) ? 4'hF : msk[3:0];
      o.t = h[31:28];
      o.e = (rem <= 4) && h[25];
      push_w(o.d, 1'b0, 1'b1);
      exp_q.push_back(o);
    end
  endfunction

  function automatic void add_stat(input bit ok);
    logic [27:0] r;
    r = 28'($urandom);
    push_w({ok ? 4'hE : 4'hF, r}, 1'b1, 1'b0);
  endfunction

  function automatic void add_rand_msg();
    int nseg;
    logic [3:0] t;
    logic [3:0] f;
    logic [7:0] mid;
    nseg = $urandom_range(4, 1);
    for (int s = 0; s < nseg; s++) begin
      t = 4'($urandom_range(13));
      f = 4'($urandom);
      mid = 8'($urandom);
      add_seg({t, f, mid, 16'($urandom_range(20))});
    end
    add_stat(1'($urandom));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.do_valid = 1'b0;
    bus.do_last = 1'b0;
    bus.do_data = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_do_ready", bus.do_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_keep", bus.out_keep, 0);
    chk("rst_out_type", bus.out_type, 0);
    chk("rst_out_eot", bus.out_eot, 0);
    chk("rst_msg_done", msg_done, 0);
    chk("rst_msg_success", msg_success, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_pld_bytes", pld_bytes, 0);
    @(negedge clk);
    rst = 1'b0;
    succ_model = 0;
    pld_model = 0;
    exp_q.delete();
  endtask

  task automatic run_msgs(input int stall_lo, input int stall_hi,
                          input int rdy_pct);
    int          idx = 0;
    int          cyc = 0;
    bit          done_exp = 0;
    bit          succ_pend = 0;
    bit          held = 0;
    bit          er;
    logic [31:0] hdata = '0;
    ow_t         o;
    int          epld;
    while ((idx < wq.size() || exp_q.size() != 0 || done_exp)
           && cyc < 4000) begin
      @(negedge clk);
      bus.do_valid = (idx < wq.size()) && ($urandom_range(3) != 0);
      bus.do_data = bus.do_valid ? wq[idx] : $urandom;
      bus.do_last = bus.do_valid ? lq[idx] : 1'b0;
      bus.out_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 :
                      ($urandom_range(99) < rdy_pct);
      #1;
      if (done_exp)
        succ_model = succ_pend;
      chk("msg_done", msg_done, done_exp);
      chk("msg_success", msg_success, succ_model);
      chk("proto_err", proto_err, 0);
      er = (idx < wq.size() && dq[idx]) ?
           (!bus.out_valid || bus.out_ready) : 1'b1;
      chk("do_ready", bus.do_ready, er);
`ifdef LWC_DO_BYTECNT_EN
      epld = pld_model;
`else
      epld = 0;
`endif
      chk("pld_bytes", pld_bytes, epld);
      if (held) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, hdata);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          o = exp_q.pop_front();
          chk("out_data", bus.out_data, o.d);
          chk("out_keep", bus.out_keep, o.k);
          chk("out_type", bus.out_type, o.t);
          chk("out_eot", bus.out_eot, o.e);
          if (!msg_done) begin
            pld_model += $countones(o.k);
            if (pld_model > 65535)
              pld_model = 65535;
          end
        end
      end
      if (msg_done)
        pld_model = 0;
      held = bus.out_valid && !bus.out_ready;
      hdata = bus.out_data;
      done_exp = 0;
      if (bus.do_valid && bus.do_ready) begin
        if (lq[idx]) begin
          done_exp = 1;
          succ_pend = (wq[idx][31:28] == 4'hE);
        end
        idx++;
      end
      cyc++;
    end
    if (cyc >= 4000)
      chk("timeout", 1, 0);
    wq.delete();
    lq.delete();
    dq.delete();
    @(negedge clk);
    bus.do_valid = 1'b0;
    bus.do_last = 1'b0;
  endtask

  task automatic err_test(input int kind);
    do_reset();
    bus.out_ready = 1'b1;
    if (kind == 0) begin
      push_w(32'h31000008, 1'b0, 1'b0);
      push_w(32'hA1A2A3A4, 1'b0, 1'b1);
      push_w(32'hB1B2B3B4, 1'b1, 1'b1);
    end else if (kind == 1) begin
      push_w(32'hE0000000, 1'b0, 1'b0);
    end else begin
      push_w(32'h31000008, 1'b1, 1'b0);
    end
    for (int i = 0; i < wq.size(); i++) begin
      @(negedge clk);
      bus.do_valid = 1'b1;
      bus.do_data = wq[i];
      bus.do_last = lq[i];
      #1;
      chk("err_feed_ready", bus.do_ready, 1);
      if (kind == 0 && i == 2) begin
        chk("err_pre_valid", bus.out_valid, 1);
        chk("err_pre_data", bus.out_data, 32'hA1A2A3A4);
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.do_valid = 1'($urandom);
      bus.do_data = $urandom;
      bus.do_last = 1'($urandom);
      bus.out_ready = 1'($urandom);
      #1;
      chk("err_proto", proto_err, 1);
      chk("err_do_ready", bus.do_ready, 1);
      chk("err_out_valid", bus.out_valid, 0);
      chk("err_msg_done", msg_done, 0);
    end
    wq.delete();
    lq.delete();
    dq.delete();
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.do_valid = 1'b0;
    bus.do_last = 1'b0;
    bus.do_data = '0;
    bus.out_ready = 1'b0;
    do_reset();

    pay_q = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    add_seg(32'h52000010);
    add_stat(1'b1);
    run_msgs(4, 9, 100);

    pay_q = '{32'hAABBCCDD, 32'hEEFF0000};
    add_seg(32'h52000006);
    add_stat(1'b0);
    run_msgs(0, 0, 70);

    add_seg(32'h52000016);
    add_stat(1'b1);
    run_msgs(0, 0, 100);

    for (int m = 0; m < 25; m++) begin
      add_rand_msg();
      run_msgs(0, 0, 40 + $urandom_range(60));
    end

    for (int k = 0; k < 3; k++)
      err_test(k);

    @(negedge clk);
    bus.do_valid = 1'b1;
    bus.do_last = 1'b0;
    bus.do_data = 32'h12000010;
    @(negedge clk);
    bus.do_data = 32'h55555555;
    do_reset();
    for (int m = 0; m < 3; m++) begin
      add_rand_msg();
      run_msgs(0, 0, 80);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lwc_do_receiver.md
Name: lwc_do_receiver

Overview:
- Consumer-side endpoint of the LWC data-output (DO) interface: accepts the core's do_data/do_valid/do_last word stream, parses segment headers and the trailing status word, and forwards payload words with byte-enables and segment type to a downstream sink.
- Serves as the synthesizable DO-side counterpart to the PDI/SDI stimulus drivers. Used in system wrappers and as a checker in benches.

Parameters:
- BUSW, 32, DO bus width in bits; multiple of 8, minimum 32.
- STAT_SUCCESS, 4'hE, status-word opcode for success (data[BUSW-1:BUSW-4]).
- STAT_FAILURE, 4'hF, status-word opcode for failure.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- do_data  in  BUSW  DO word from core; byte 0 is at the MSBs.
- do_valid  in  1  do_data valid.
- do_last  in  1  marks the final word of the message (the status word).
- do_ready  out  1  receiver accepts the word this cycle.
- out_data  out  BUSW  registered payload word.
- out_keep  out  BUSW/8  byte valid mask; bit BUSW/8-1 corresponds to byte 0 (MSB byte).
- out_type  out  4  segment type of the current payload word.
- out_eot  out  1  last word of a segment flagged "last".
- out_valid  out  1  payload word valid.
- out_ready  in  1  sink accepts the payload word.
- msg_done  out  1  one-cycle pulse when the status word is accepted.
- msg_success  out  1  latched result of the last status word (1 = STAT_SUCCESS).
- proto_err  out  1  sticky protocol error flag.
- pld_bytes  out  16  payload byte count; see Optional Feature.

Behaviour:
- Reset values: do_ready=0, out_valid=0, out_data=0, out_keep=0, out_type=0, out_eot=0, msg_done=0, msg_success=0, proto_err=0, pld_bytes=0. FSM goes to HDR.
- Handshake rules:
  - A word transfers when do_valid && do_ready.
  - Output transfers when out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
- Header word format:
  - [BUSW-1:BUSW-4] = type.
  - [BUSW-5:BUSW-8] = flags; bit1 = last-segment.
  - [15:0] = segment length in bytes.
  - Other bits are ignored.
- FSM states: HDR, DATA, ERR.
- HDR:
  - do_ready=1.
  - Type equal to STAT_SUCCESS or STAT_FAILURE: the word is a status word.
    - With do_last=1: msg_done=1 for the next cycle only; msg_success <= (type==STAT_SUCCESS); stay in HDR.
    - With do_last=0: go to ERR.
  - Any other type: segment header; latch type, last flag and length into rem_len.
    - Length 0: stay in HDR, emit nothing.
    - Length nonzero: go to DATA.
    - do_last=1 on a segment header: go to ERR.
- DATA:
  - do_ready = !out_valid || out_ready, which gives a one-entry output register with full throughput.
  - On each accepted word, register it into out_data and set out_valid=1 and out_type=latched type.
  - out_keep: all ones if rem_len >= BUSW/8; otherwise the top rem_len bits are set, e.g. rem_len=3 at BUSW=32 gives 4'b1110.
  - Decrement rem_len by min(rem_len, BUSW/8).
  - Final word (rem_len <= BUSW/8): out_eot = latched last flag; return to HDR.
  - do_last=1 in DATA: go to ERR; the word is not forwarded.
- ERR:
  - proto_err=1; do_ready=1, so the stream is drained and discarded.
  - out_valid clears once the pending word is accepted.
  - Only rst exits ERR.
- Simultaneous events: a new output load and a sink accept in the same cycle keep out_valid=1 with the new word. msg_done cannot coincide with a DATA accept.
- Reset mid-message: all state is abandoned; the next word is parsed as a header.
- Latency: one cycle from DO accept to out_valid.

Optional Feature:
- Macro: LWC_DO_BYTECNT_EN.
- Defined:
  - pld_bytes accumulates the number of set out_keep bits on each output transfer.
  - Clears on msg_done and rst; saturates at 16'hFFFF.
- Undefined: pld_bytes is tied to 0 and no counter logic is built.

Test Plan (BUSW=32):
- Segment header 0x52000010, then 4 data words 0x00010203.., then status 0xE0000000 with do_last -> 4 out words, out_type=5, out_keep=4'hF, out_eot=1 on the 4th; msg_done pulse; msg_success=1.
- Header 0x52000006, words 0xAABBCCDD and 0xEEFF0000 -> out_keep 4'hF then 4'hC; out_eot=1 on the second word.
- out_ready held 0 for 5 cycles mid-segment -> out_data stable; do_ready=0; no word lost or duplicated once released.
- Status 0xF0000000 with do_last -> msg_success=0, msg_done=1 for exactly 1 cycle.
- do_last asserted on a data word -> proto_err=1 sticky; do_ready=1; stays set until rst.
- LWC_DO_BYTECNT_EN defined, 22-byte segment (0x52000016) then status -> pld_bytes=22 before msg_done, 0 after.
